veritune_mem_ctrl: RTL
======================

// Module: veritune_mem_ctrl
// PURPOSE
//  Owns the single-port audio sample RAM (2^17 x 16). It sequences the record, pitch-shift and playback phases.
//  It arbitrates RAM access between three requesters: recorder (sequential write), shift engine (random R/W)
//  and player (sequential read). It tracks the recorded length. It sits between veritune_sm and the RAM/FFT path.
// PARAMETERS
//  ADDR_W   17      RAM address width
//  DATA_W   16      sample width
//  MAX_LEN  131070  max samples recorded; Full asserts at this count
// PORTS
//  Clk          in   1       system clock, all logic on posedge
//  Reset_n      in   1       asynchronous, active-low reset
//  Rec_Start    in   1       pulse: enter RECORD, clear length
//  Stop         in   1       pulse: leave RECORD/PLAY -> HOLD
//  Play_Start   in   1       pulse: enter PLAY from HOLD, rd_ptr=0
//  Rec_Req      in   1       recorder has sample on Rec_Data
//  Rec_Data     in   DATA_W  sample to store
//  Rec_Ack      out  1       sample written this cycle
//  Rec_Drop     out  1       pulse: Rec_Req refused because Full
//  Sh_Req       in   1       shift engine access request
//  Sh_We        in   1       1=write, 0=read
//  Sh_Addr      in   ADDR_W  shift address (must be < Length; else ignored, Sh_Err pulses)
//  Sh_Wdata     in   DATA_W  shift write data
//  Sh_Ack       out  1       shift access granted
//  Sh_Err       out  1       pulse: out-of-range address
//  Play_Req     in   1       player wants next sample
//  Play_Ack     out  1       play read granted
//  Rd_Valid     out  1       Rd_Data valid (1 cycle after read grant)
//  Rd_Owner     out  1       0=shift, 1=player, for Rd_Valid
//  Rd_Data      out  DATA_W  read sample
//  Play_Last    out  1       with Rd_Valid: sample at Length-1
//  Length       out  ADDR_W  samples recorded
//  Full         out  1       Length == MAX_LEN
//  Phase        out  2       00 IDLE, 01 RECORD, 10 HOLD, 11 PLAY
//  Mem_En, Mem_We  out  1    RAM strobes
//  Mem_Addr     out  ADDR_W  RAM address
//  Mem_Wdata    out  DATA_W  RAM write data
//  Mem_Rdata    in   DATA_W  RAM read data, valid 1 cycle after Mem_En&!Mem_We
// BEHAVIOUR
//  Reset: Phase=IDLE; Length, wr_ptr and rd_ptr are 0. All acks, pulses, Rd_Valid, Mem_En and Full are 0.
//    An in-flight read is discarded and produces no Rd_Valid. Data outputs reset to 0.
//  Phase FSM, evaluated in priority order Rec_Start > Stop > Play_Start:
//    IDLE   -Rec_Start-> RECORD
//    RECORD -Stop|Full-> HOLD
//    HOLD   -Play_Start-> PLAY   (only if Length!=0)
//    HOLD   -Rec_Start-> RECORD
//    PLAY   -Stop-> HOLD
//    PLAY   -Rec_Start-> RECORD
//    Rec_Start in any phase: Length=0, wr_ptr=0.
//  Eligibility:
//    Rec_Req only in RECORD and !Full.
//    Sh_Req only in HOLD/PLAY.
//    Play_Req only in PLAY.
//  One grant per cycle. Grant, ack and Mem_* are all registered in the same cycle (combinational grant, 0 latency).
//  Record grant: Mem_Addr=wr_ptr; wr_ptr++ and Length++. When Length reaches MAX_LEN: Full=1 and next cycle Phase=HOLD.
//  Rec_Req while Full: no write, Rec_Drop=1 for that cycle.
//  Play grant: Mem_Addr=rd_ptr. rd_ptr wraps to 0 after Length-1. Play_Last is tagged with that read.
//  Read latency: Rd_Valid/Rd_Data/Rd_Owner exactly 1 cycle after the read grant. Back-to-back reads are allowed.
//  Shift write to an address equal to the current rd_ptr in the same cycle: only one is granted; no hazard.
//  Stop with a read in flight: the read still completes (Rd_Valid emitted).
// CONFIGURATION
//  VT_ROUND_ROBIN_EN defined:
//    Round-robin among eligible requesters.
//    The last-granted requester has lowest priority next cycle.
//    The pointer starts at recorder after reset.
//  Not defined:
//    Fixed priority Rec > Shift > Play. Starvation of Play is allowed.
// STRUCTURE
//  veritune_pkg:
//    Phase encodings.
//    Requester IDs (REQ_REC=0, REQ_SH=1, REQ_PLAY=2).
//    ADDR_W, DATA_W and MAX_LEN defaults.
//  Sub-module veritune_rr_arb: 3-way arbiter with request/eligible mask in, one-hot grant out.
//    Holds the RR pointer under VT_ROUND_ROBIN_EN; otherwise it is pure fixed-priority logic.
// TESTING
//  1. Rec_Start, then 5 cycles Rec_Req with Data 1..5, then Stop
//     -> Mem writes at addresses 0..4; Length=5; Phase=HOLD.
//  2. Play_Start, Play_Req held for 7 cycles
//     -> reads at addresses 0,1,2,3,4,0,1.
//     -> Rd_Valid 1 cycle after each grant; Play_Last on address 4.
//  3. Set MAX_LEN=4; record 6 requests
//     -> 4 writes; Full=1; Rec_Drop on requests 5 and 6; Phase=HOLD.
//  4. In PLAY, Sh_Req+Play_Req together for 4 cycles
//     -> fixed: Sh,Sh,Sh,Sh.
//     -> RR: alternating Sh/Play.
//     -> Sh_Addr=Length gives Sh_Err and no Mem_En.
//  5. Reset_n low for 1 cycle mid-play with a read in flight
//     -> no Rd_Valid; Phase=IDLE; Length=0; all outputs 0.
//  6. Rec_Start and Play_Start in the same cycle in HOLD
//     -> RECORD; Length=0. Play_Start in HOLD with Length=0 -> stays HOLD.

Source files
------------

// File: rtl/veritune_pkg.sv
// veritune shared definitions: phase codes, requester ids, size defaults.
// Arbitration mode selected by VT_ROUND_ROBIN_EN (see veritune_rr_arb).
package veritune_pkg;

  localparam int ADDR_W_D  = 17;
  localparam int DATA_W_D  = 16;
  localparam int MAX_LEN_D = 131070;

  localparam logic [1:0] PH_IDLE   = 2'b00;
  localparam logic [1:0] PH_RECORD = 2'b01;
  localparam logic [1:0] PH_HOLD   = 2'b10;
  localparam logic [1:0] PH_PLAY   = 2'b11;

  localparam int REQ_REC  = 0;
  localparam int REQ_SH   = 1;
  localparam int REQ_PLAY = 2;

  function automatic logic [1:0] req_next(
    input logic [1:0] id
  );
    return (id == 2'd2) ? 2'd0 : id + 2'd1;
  endfunction

endpackage

// File: rtl/veritune_rr_arb.sv
// 3-way RAM arbiter, one-hot grant out.
// VT_ROUND_ROBIN_EN: rotating priority; otherwise fixed Rec > Sh > Play.
module veritune_rr_arb
  import veritune_pkg::*;
(
`ifdef VT_ROUND_ROBIN_EN
  input  logic       Clk,
  input  logic       Reset_n,
`endif
  input  logic [2:0] Req,
  input  logic [2:0] Elig,
  output logic [2:0] Gnt
);

  logic [2:0] act;
  assign act = Req & Elig;

`ifdef VT_ROUND_ROBIN_EN
  // ptr_q is the highest-priority id; it moves past the winner
  logic [1:0] ptr_q;
  logic [1:0] idx;
  logic [1:0] gid;
  logic       found;

  always_comb begin
    Gnt   = '0;
    idx   = ptr_q;
    gid   = ptr_q;
    found = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (!found && act[idx]) begin
        Gnt[idx] = 1'b1;
        gid      = idx;
        found    = 1'b1;
      end
      idx = req_next(idx);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ptr_q <= 2'(REQ_REC);
    end else if (found) begin
      ptr_q <= req_next(gid);
    end
  end
`else
  always_comb begin
    Gnt = '0;
    if (act[REQ_REC]) begin
      Gnt[REQ_REC] = 1'b1;
    end else if (act[REQ_SH]) begin
      Gnt[REQ_SH] = 1'b1;
    end else if (act[REQ_PLAY]) begin
      Gnt[REQ_PLAY] = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/veritune_mem_ctrl.sv
// veritune sample RAM owner: phase FSM, arbitration, length tracking.
// Arbitration mode selected by VT_ROUND_ROBIN_EN.
module veritune_mem_ctrl
  import veritune_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_D,
  parameter int DATA_W  = DATA_W_D,
  parameter int MAX_LEN = MAX_LEN_D
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Rec_Start,
  input  logic              Stop,
  input  logic              Play_Start,
  input  logic              Rec_Req,
  input  logic [DATA_W-1:0] Rec_Data,
  output logic              Rec_Ack,
  output logic              Rec_Drop,
  input  logic              Sh_Req,
  input  logic              Sh_We,
  input  logic [ADDR_W-1:0] Sh_Addr,
  input  logic [DATA_W-1:0] Sh_Wdata,
  output logic              Sh_Ack,
  output logic              Sh_Err,
  input  logic              Play_Req,
  output logic              Play_Ack,
  output logic              Rd_Valid,
  output logic              Rd_Owner,
  output logic [DATA_W-1:0] Rd_Data,
  output logic              Play_Last,
  output logic [ADDR_W-1:0] Length,
  output logic              Full,
  output logic [1:0]        Phase,
  output logic              Mem_En,
  output logic              Mem_We,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Mem_Wdata,
  input  logic [DATA_W-1:0] Mem_Rdata
);

  localparam logic [ADDR_W-1:0] MAX_L = ADDR_W'(MAX_LEN);

  logic [1:0]        phase_q, phase_d;
  logic [ADDR_W-1:0] len_q, wr_ptr_q, rd_ptr_q;
  logic              rd_iss_q, own_iss_q, last_iss_q;
  logic [2:0]        req, elig, gnt;
  logic              in_hp, sh_ok, rd_last, play_go;

  assign Phase   = phase_q;
  assign Length  = len_q;
  assign Full    = (len_q == MAX_L);
  assign in_hp   = (phase_q == PH_HOLD) || (phase_q == PH_PLAY);
  assign sh_ok   = (Sh_Addr < len_q);
  assign rd_last = (rd_ptr_q == len_q - 1'b1);
  assign play_go = (phase_q == PH_HOLD) && Play_Start && (len_q != '0);
  assign Rd_Data = Rd_Valid ? Mem_Rdata : '0;

  assign req = {Play_Req, Sh_Req, Rec_Req};

  // a restart wins the write pointer, so no record grant that cycle
  assign elig[REQ_REC]  = (phase_q == PH_RECORD) && !Full && !Rec_Start;
  assign elig[REQ_SH]   = in_hp && sh_ok;
  assign elig[REQ_PLAY] = (phase_q == PH_PLAY);

  veritune_rr_arb u_arb (
`ifdef VT_ROUND_ROBIN_EN
    .Clk     (Clk),
    .Reset_n (Reset_n),
`endif
    .Req     (req),
    .Elig    (elig),
    .Gnt     (gnt)
  );

  always_comb begin
    phase_d = phase_q;
    if (Rec_Start) begin
      phase_d = PH_RECORD;
    end else begin
      case (phase_q)
        PH_RECORD: if (Stop || Full) phase_d = PH_HOLD;
        PH_PLAY:   if (Stop) phase_d = PH_HOLD;
        PH_HOLD:   if (play_go) phase_d = PH_PLAY;
        default:   phase_d = phase_q;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      phase_q    <= PH_IDLE;
      len_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      Rec_Ack    <= 1'b0;
      Rec_Drop   <= 1'b0;
      Sh_Ack     <= 1'b0;
      Sh_Err     <= 1'b0;
      Play_Ack   <= 1'b0;
      Mem_En     <= 1'b0;
      Mem_We     <= 1'b0;
      Mem_Addr   <= '0;
      Mem_Wdata  <= '0;
      rd_iss_q   <= 1'b0;
      own_iss_q  <= 1'b0;
      last_iss_q <= 1'b0;
      Rd_Valid   <= 1'b0;
      Rd_Owner   <= 1'b0;
      Play_Last  <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      Rec_Ack  <= gnt[REQ_REC];
      Sh_Ack   <= gnt[REQ_SH];
      Play_Ack <= gnt[REQ_PLAY];
      Rec_Drop <= Rec_Req && Full;
      Sh_Err   <= Sh_Req && in_hp && !sh_ok;
      Mem_En   <= |gnt;
      Mem_We   <= gnt[REQ_REC] || (gnt[REQ_SH] && Sh_We);
      unique case (1'b1)
        gnt[REQ_REC]: begin
          Mem_Addr  <= wr_ptr_q;
          Mem_Wdata <= Rec_Data;
        end
        gnt[REQ_SH]: begin
          Mem_Addr  <= Sh_Addr;
          Mem_Wdata <= Sh_We ? Sh_Wdata : '0;
        end
        gnt[REQ_PLAY]: begin
          Mem_Addr  <= rd_ptr_q;
          Mem_Wdata <= '0;
        end
        default: begin
          Mem_Addr  <= '0;
          Mem_Wdata <= '0;
        end
      endcase
      if (Rec_Start) begin
        len_q    <= '0;
        wr_ptr_q <= '0;
      end else if (gnt[REQ_REC]) begin
        len_q    <= len_q + 1'b1;
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (play_go && !Rec_Start) begin
        rd_ptr_q <= '0;
      end else if (gnt[REQ_PLAY]) begin
        rd_ptr_q <= rd_last ? '0 : rd_ptr_q + 1'b1;
      end
      // RAM answers one cycle after the strobe, so tag a two-stage pipe
      rd_iss_q   <= (gnt[REQ_SH] && !Sh_We) || gnt[REQ_PLAY];
      own_iss_q  <= gnt[REQ_PLAY];
      last_iss_q <= gnt[REQ_PLAY] && rd_last;
      Rd_Valid   <= rd_iss_q;
      Rd_Owner   <= own_iss_q;
      Play_Last  <= last_iss_q;
    end
  end

endmodule
